// File: rtl/ysyx_22040365_pipe_ctrl.sv
// Pipeline control for the five-stage ysyx_22040365 core: resolves memory
// wait states, taken-branch redirects and load-use hazards into per-stage hold/flush/commit controls.
module ysyx_22040365_pipe_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic        id_rs1_ren,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs2_ren,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_en,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        wb_en,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2
  } mem_state_e;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  // Handshake: mem_req is held by the MEM stage for the whole access; the
  // access completes in any cycle where mem_req & mem_ready are both high.
  // mem_ready without mem_req (IDLE) is ignored.
  mem_state_e  state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        mem_stall;
  logic        lu_hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= 8'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        wcnt_d = 8'd0;
        if (mem_req && !mem_ready) begin
          state_d   = S_BUSY;
          mem_stall = 1'b1;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_d = S_IDLE;
          wcnt_d  = 8'd0;
        end else begin
          mem_stall = 1'b1;
          if (wcnt_q == WCNT_LAST) state_d = S_ERR;
          else                     wcnt_d  = wcnt_q + 8'd1;
        end
      end
      S_ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu_hazard = ex_is_load && ex_rd_en && (ex_rd_addr != 5'd0) &&
                     ((id_rs1_ren && (id_rs1_addr == ex_rd_addr)) ||
                      (id_rs2_ren && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    wb_en     = 1'b1;
    if (mem_stall) begin
      // EX is frozen, so a pending branch/hazard is seen again after the access.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      wb_en     = 1'b0;
    end else if (ex_br_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (lu_hazard) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  assign mem_err     = (state_q == S_ERR);
  assign stall_cnt   = stall_cnt_q;
  assign dbg_state_o = state_q;

endmodule
